// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    KILL  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instruction} pairs feeding decode.
// Flush empties it in one cycle; head is read from the storage registers.
module fetch_queue #(
  parameter int unsigned LEN   = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic [LEN-1:0] push_pc,
  input  logic [31:0]    push_data,
  input  logic           pop,
  input  logic           flush,
  output logic [LEN-1:0] head_pc,
  output logic [31:0]    head_data,
  output logic [CW-1:0]  count,
  output logic           empty,
  output logic           full
);

  logic [LEN-1:0] pc_q   [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head_pc   = pc_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        pc_q[wr_ptr]   <= push_pc;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one request at a time,
// buffers responses for decode and handles redirects/flushes.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned    LEN      = 32,
  parameter int unsigned    QDEPTH   = 4,
  parameter logic [LEN-1:0] RESET_PC = LEN'(DEF_RESET_PC)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rdy_in,
  output logic           mem_req_valid,
  output logic [LEN-1:0] mem_req_addr,
  input  logic           mem_req_ready,
  input  logic           mem_resp_valid,
  input  logic [31:0]    mem_resp_data,
  input  logic           redirect_valid,
  input  logic [LEN-1:0] redirect_pc,
  output logic           inst_valid,
  output logic [31:0]    inst_data,
  output logic [LEN-1:0] inst_pc,
  input  logic           inst_ready,
  output logic           busy
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  fetch_state_t   state;
  fetch_state_t   state_n;
  logic [LEN-1:0] fetch_pc;
  logic [LEN-1:0] fetch_pc_n;
  logic [LEN-1:0] pending_pc;
  logic [LEN-1:0] pending_pc_n;

  logic           redir;
  logic           req_fire;
  logic           resp_acc;
  logic           pop;
  logic           push;
  logic           flush;
  logic           outstanding;
  logic [CW-1:0]  count;
  logic           empty;
  logic           full;
  logic           unused_ok;

  assign outstanding   = (state == WAIT) | (state == KILL);
  assign mem_req_valid = (state == FETCH);
  assign mem_req_addr  = fetch_pc;
  assign busy          = outstanding;
  assign inst_valid    = ~empty;

  assign redir    = redirect_valid & rdy_in;
  assign req_fire = mem_req_valid & mem_req_ready & rdy_in;
  assign resp_acc = mem_resp_valid & rdy_in;
  // A redirect kills any same-cycle pop along with the queue contents
  assign pop      = inst_valid & inst_ready & rdy_in & ~redirect_valid;
  assign push     = (state == WAIT) & resp_acc & ~redirect_valid;
  assign flush    = redir;

  assign unused_ok = ^{redirect_pc[1:0], full};

  always_comb begin
    state_n      = state;
    fetch_pc_n   = fetch_pc;
    pending_pc_n = pending_pc;
    if (redir) begin
      fetch_pc_n = {redirect_pc[LEN-1:2], 2'b00};
      if (req_fire) begin
        state_n = KILL;
      end else if (outstanding & ~resp_acc) begin
        state_n = KILL;
      end else begin
        state_n = FETCH;
      end
    end else if (rdy_in) begin
      unique case (state)
        FETCH: begin
          if (req_fire) begin
            pending_pc_n = fetch_pc;
            fetch_pc_n   = fetch_pc + LEN'(INST_BYTES);
            state_n      = WAIT;
          end
        end
        WAIT: begin
          if (resp_acc) begin
            if (pop | (count + CW'(1) < CW'(QDEPTH))) begin
              state_n = FETCH;
            end else begin
              state_n = HOLD;
            end
          end
        end
        KILL: begin
          if (resp_acc) begin
            state_n = FETCH;
          end
        end
        HOLD: begin
          if (pop) begin
            state_n = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
    end else begin
      state      <= state_n;
      fetch_pc   <= fetch_pc_n;
      pending_pc <= pending_pc_n;
    end
  end

  fetch_queue #(
    .LEN   (LEN),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_pc   (pending_pc),
    .push_data (mem_resp_data),
    .pop       (pop),
    .flush     (flush),
    .head_pc   (inst_pc),
    .head_data (inst_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a queue-based reference model.
module tb_fetch_ctrl;

  localparam int unsigned LEN    = 32;
  localparam int unsigned QDEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rdy_in = 1'b0;
  logic            mem_req_valid;
  logic [LEN-1:0]  mem_req_addr;
  logic            mem_req_ready = 1'b0;
  logic            mem_resp_valid = 1'b0;
  logic [31:0]     mem_resp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [LEN-1:0]  redirect_pc = '0;
  logic            inst_valid;
  logic [31:0]     inst_data;
  logic [LEN-1:0]  inst_pc;
  logic            inst_ready = 1'b0;
  logic            busy;

  fetch_ctrl #(
    .LEN      (LEN),
    .QDEPTH   (QDEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy_in         (rdy_in),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int redirects = 0;

  // reference model: expected fetch pc, one outstanding request, FIFO of pcs
  logic [31:0] m_pc;
  logic        m_out;
  logic        m_keep;
  logic [31:0] m_pend;
  logic [31:0] mq[$];

  // memory model
  logic        mpend;
  int          mcnt;
  logic [31:0] maddr;

  // stimulus knobs (percent, or per-mille for redirects)
  int k_stall, k_mready, k_iready, k_lat, k_rd;
  logic        shot_valid = 1'b0;
  logic [31:0] shot_pc = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst_n          = 1'b0;
    rdy_in         = 1'b0;
    mem_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    m_pc   = 32'h0;
    m_out  = 1'b0;
    m_keep = 1'b0;
    m_pend = 32'h0;
    mq.delete();
    mpend  = 1'b0;
    mcnt   = 0;
    #1;
    check("rst_req_valid", mem_req_valid, 1'b1);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    logic m_req, rd, fire, racc, pop;
    @(negedge clk);
    m_req = !m_out && (mq.size() < QDEPTH);
    check("req_valid", mem_req_valid, m_req);
    check("busy", busy, m_out);
    check("inst_valid", inst_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("inst_pc", inst_pc, mq[0]);
      check("inst_data", inst_data, word_of(mq[0]));
    end
    if (m_req) check("req_addr", mem_req_addr, m_pc);

    rdy_in        = ($urandom_range(99) >= k_stall);
    mem_req_ready = ($urandom_range(99) < k_mready);
    inst_ready    = ($urandom_range(99) < k_iready);
    if (shot_valid) begin
      redirect_valid = 1'b1;
      redirect_pc    = shot_pc;
      rdy_in         = 1'b1;
      shot_valid     = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(999) < k_rd);
      redirect_pc = ($urandom_range(3) == 0) ?
                    (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
    end
    mem_resp_valid = mpend && (mcnt == 0);
    mem_resp_data  = mem_resp_valid ? word_of(maddr) : $urandom;

    rd   = redirect_valid && rdy_in;
    fire = m_req && mem_req_ready && rdy_in;
    racc = mem_resp_valid && rdy_in;
    pop  = (mq.size() != 0) && inst_ready && rdy_in && !rd;

    if (fire) begin
      mpend = 1'b1;
      mcnt  = $urandom_range(k_lat - 1);
      maddr = mem_req_addr;
    end else if (racc) begin
      mpend = 1'b0;
    end else if (mpend && mcnt > 0) begin
      mcnt--;
    end

    if (rd) begin
      redirects++;
      mq.delete();
      m_out  = (m_out && !racc) || fire;
      m_keep = 1'b0;
      m_pc   = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        pops++;
      end
      if (racc && m_out) begin
        if (m_keep) mq.push_back(m_pend);
        m_out = 1'b0;
      end
      if (fire) begin
        m_out  = 1'b1;
        m_keep = 1'b1;
        m_pend = m_pc;
        m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic knobs(input int st, input int mr, input int ir,
                       input int lat, input int rdp);
    k_stall = st; k_mready = mr; k_iready = ir; k_lat = lat; k_rd = rdp;
  endtask

  initial begin
    knobs(0, 100, 100, 1, 0);
    reset_all();
    run(20);

    knobs(0, 100, 0, 2, 0);
    run(40);
    knobs(0, 100, 100, 2, 0);
    run(10);

    knobs(0, 100, 100, 3, 0);
    run(6);
    shot_valid = 1'b1;
    shot_pc    = 32'h0000_0103;
    run(30);

    knobs(0, 100, 100, 1, 0);
    shot_valid = 1'b1;
    shot_pc    = 32'hFFFF_FFF4;
    run(20);

    knobs(30, 70, 60, 4, 30);
    run(3000);

    knobs(10, 80, 50, 3, 20);
    run(7);
    reset_all();
    run(300);

    knobs(60, 90, 90, 2, 5);
    run(500);

    check("progress_pops", pops > 300, 1'b1);
    check("progress_redirects", redirects > 20, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
